// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller sharing one byte-wide RAM port between fetch and load/store.
// Optional MEM_CTRL_RR_ARB_EN: round-robin arbitration on simultaneous requests (default: MEM wins).
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr,
    output logic              busy
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t            r_state;
    logic              r_own_mem;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_if_done;
    logic [31:0]       r_if_data;
    logic              r_mem_done;
    logic [31:0]       r_mem_rdata;
    logic [ADDR_W-1:0] r_ram_a;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr;
    logic              r_busy;
`ifdef MEM_CTRL_RR_ARB_EN
    logic              r_last_mem;
`endif

    logic              w_any_req;
    logic              w_pick_mem;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [2:0]        w_grant_len;
    logic [2:0]        w_cnt_inc;
    logic              w_last_step;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [1:0]        w_wr_idx;
    logic [7:0]        w_wbyte_nxt;
    logic [1:0]        w_cap_idx;
    logic [31:0]       w_rdata_cap;

    // Grant selection and per-byte datapath helpers
    always_comb begin
        w_any_req = if_req | mem_req;
`ifdef MEM_CTRL_RR_ARB_EN
        w_pick_mem = mem_req & (~if_req | ~r_last_mem);
`else
        w_pick_mem = mem_req;
`endif
        w_grant_addr = w_pick_mem ? mem_addr : if_addr;
        if (!w_pick_mem || mem_len[1]) begin
            w_grant_len = 3'd4;
        end else begin
            w_grant_len = mem_len[0] ? 3'd2 : 3'd1;
        end
        w_cnt_inc   = r_cnt + 3'd1;
        w_last_step = (w_cnt_inc >= r_len);
        w_addr_nxt  = r_addr + ADDR_W'(w_cnt_inc);
        w_wr_idx    = w_cnt_inc[1:0];
        w_wbyte_nxt = r_wdata[{w_wr_idx, 3'b000} +: 8];
        // RAM data lags the address by one cycle, so cycle k holds byte k-1
        w_cap_idx   = 2'(r_cnt - 3'd1);
        w_rdata_cap = r_rdata;
        w_rdata_cap[{w_cap_idx, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_own_mem   <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_if_done   <= 1'b0;
            r_if_data   <= '0;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= '0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MEM_CTRL_RR_ARB_EN
            r_last_mem  <= 1'b0;
`endif
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_own_mem <= w_pick_mem;
                        r_addr    <= w_grant_addr;
                        r_len     <= w_grant_len;
                        r_wdata   <= mem_wdata;
                        r_rdata   <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_ram_a   <= w_grant_addr;
                        if (w_pick_mem && mem_we) begin
                            r_state    <= S_WR;
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= mem_wdata[7:0];
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_cnt   <= w_cnt_inc;
                    r_ram_a <= w_last_step ? '0 : w_addr_nxt;
                    if (r_cnt != 3'd0) begin
                        r_rdata <= w_rdata_cap;
                    end
                    if (r_cnt == r_len) begin
                        r_state <= S_DONE;
                        if (r_own_mem) begin
                            r_mem_done  <= 1'b1;
                            r_mem_rdata <= w_rdata_cap;
                        end else begin
                            r_if_done <= 1'b1;
                            r_if_data <= w_rdata_cap;
                        end
`ifdef MEM_CTRL_RR_ARB_EN
                        r_last_mem <= r_own_mem;
`endif
                    end
                end
                S_WR: begin
                    r_cnt <= w_cnt_inc;
                    if (w_last_step) begin
                        r_state    <= S_DONE;
                        r_ram_a    <= '0;
                        r_ram_dout <= '0;
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
`ifdef MEM_CTRL_RR_ARB_EN
                        r_last_mem <= 1'b1;
`endif
                    end else begin
                        r_ram_a    <= w_addr_nxt;
                        r_ram_dout <= w_wbyte_nxt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_done   = r_if_done;
    assign if_data   = r_if_data;
    assign mem_done  = r_mem_done;
    assign mem_rdata = r_mem_rdata;
    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;
    assign ram_wr    = r_ram_wr;
    assign busy      = r_busy;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a timeline model of expected per-cycle outputs for mem_ctrl.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic        if_done, mem_done, ram_wr, busy;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic [7:0]  ram_dout, ram_din;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit m_last_mem = 1'b0;
    int last_if_cyc, last_mem_cyc;
    logic [31:0] last_if_data, last_mem_data;

    // Expected timeline keyed by cycle number; absent entries mean "0 / idle"
    logic [31:0] exp_a    [int];
    bit          exp_a_dc [int];
    bit          exp_wr   [int];
    logic [7:0]  exp_dout [int];
    bit          exp_busy [int];
    logic [31:0] exp_if   [int];
    logic [31:0] exp_md   [int];
    bit          exp_mld  [int];
    logic [31:0] a_log    [int];
    logic [7:0]  ref_mem  [logic [31:0]];
    logic [7:0]  env_mem  [logic [31:0]];

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        ram_din <= env_mem.exists(ram_a) ? env_mem[ram_a] : 8'h00;
        if (ram_wr) env_mem[ram_a] = ram_dout;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [7:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Expected behaviour of one granted transaction; returns its done cycle
    function automatic int plan(bit is_mem, bit we, logic [31:0] addr, logic [1:0] len,
                                logic [31:0] wd, int t0);
        int n = (!is_mem || len[1]) ? 4 : (len[0] ? 2 : 1);
        int td = we ? t0 + n + 1 : t0 + n + 2;
        logic [31:0] d = 32'h0;
        for (int k = 0; k < n; k++) begin
            exp_a[t0 + 1 + k] = addr + 32'(k);
            if (we) begin
                exp_wr[t0 + 1 + k]   = 1'b1;
                exp_dout[t0 + 1 + k] = wd[8*k +: 8];
                ref_mem[addr + 32'(k)] = wd[8*k +: 8];
            end else begin
                d[8*k +: 8] = ref_rd(addr + 32'(k));
            end
        end
        if (!we) exp_a_dc[t0 + n + 1] = 1'b1;
        for (int t = t0 + 1; t <= td; t++) exp_busy[t] = 1'b1;
        if (is_mem) begin
            exp_md[td]  = d;
            exp_mld[td] = !we;
        end else begin
            exp_if[td] = d;
        end
        m_last_mem = is_mem;
        return td;
    endfunction

    // Per-cycle comparison against the timeline
    always @(negedge clk) begin
        if (chk_en) begin
            check("ram_wr", {31'b0, ram_wr}, {31'b0, exp_wr.exists(cyc)});
            if (!exp_a_dc.exists(cyc))
                check("ram_a", ram_a, exp_a.exists(cyc) ? exp_a[cyc] : 32'h0);
            if (exp_wr.exists(cyc)) check("ram_dout", {24'b0, ram_dout}, {24'b0, exp_dout[cyc]});
            check("busy", {31'b0, busy}, {31'b0, exp_busy.exists(cyc)});
            check("if_done", {31'b0, if_done}, {31'b0, exp_if.exists(cyc)});
            check("mem_done", {31'b0, mem_done}, {31'b0, exp_md.exists(cyc)});
            if (exp_if.exists(cyc)) check("if_data", if_data, exp_if[cyc]);
            if (exp_mld.exists(cyc) && exp_mld[cyc]) check("mem_rdata", mem_rdata, exp_md[cyc]);
            check("done_excl", {31'b0, if_done & mem_done}, 32'h0);
            if (if_done) begin last_if_cyc = cyc; last_if_data = if_data; end
            if (mem_done) begin last_mem_cyc = cyc; last_mem_data = mem_rdata; end
            a_log[cyc] = ram_a;
        end
    end

    task automatic wait_cyc(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(logic [31:0] a, logic [7:0] b);
        env_mem[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic do_req(bit is_mem, bit we, logic [31:0] addr, logic [1:0] len,
                          logic [31:0] wd, output int t0);
        int td;
        last_if_cyc = -1;
        last_mem_cyc = -1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        td = plan(is_mem, we, addr, len, wd, t0);
        wait_cyc(td + 1);
        if_req = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic contend(logic [31:0] iaddr, logic [31:0] maddr, logic [1:0] mlen);
        int t0, td1, td2;
        bit mem_first;
        last_if_cyc = -1;
        last_mem_cyc = -1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if_req = 1'b1; if_addr = iaddr;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = maddr; mem_len = mlen;
`ifdef MEM_CTRL_RR_ARB_EN
        mem_first = !m_last_mem;
`else
        mem_first = 1'b1;
`endif
        if (mem_first) begin
            td1 = plan(1'b1, 1'b0, maddr, mlen, 32'h0, t0);
            td2 = plan(1'b0, 1'b0, iaddr, 2'b10, 32'h0, td1 + 1);
        end else begin
            td1 = plan(1'b0, 1'b0, iaddr, 2'b10, 32'h0, t0);
            td2 = plan(1'b1, 1'b0, maddr, mlen, 32'h0, td1 + 1);
        end
        wait_cyc(td1 + 1);
        if (mem_first) mem_req = 1'b0; else if_req = 1'b0;
        wait_cyc(td2 + 1);
        if_req = 1'b0;
        mem_req = 1'b0;
        check("contend_order", {31'b0, last_mem_cyc < last_if_cyc}, {31'b0, mem_first});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        logic [31:0] wrap_exp [4];
        wrap_exp[0] = 32'hFFFFFFFE; wrap_exp[1] = 32'hFFFFFFFF;
        wrap_exp[2] = 32'h00000000; wrap_exp[3] = 32'h00000001;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_len = '0; mem_wdata = '0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        preload(32'h20, 8'hFF);  preload(32'h21, 8'h80);
        preload(32'hFFFFFFFE, 8'h11); preload(32'hFFFFFFFF, 8'h22);
        preload(32'h0, 8'h33);   preload(32'h1, 8'h44);

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
        rst = 1'b1;
        m_last_mem = 1'b0;
        wait_cyc(5);

        do_req(1'b0, 1'b0, 32'h100, 2'b00, 32'h0, t0);
        check("fetch_data", last_if_data, 32'h00100513);
        check("fetch_latency", 32'(last_if_cyc - t0), 32'd6);

        do_req(1'b1, 1'b1, 32'h30004, 2'b00, 32'h000000AB, t0);
        check("stb_latency", 32'(last_mem_cyc - t0), 32'd2);
        check("stb_ram", {24'b0, env_mem.exists(32'h30004) ? env_mem[32'h30004] : 8'h00}, 32'hAB);

        do_req(1'b1, 1'b0, 32'h20, 2'b01, 32'h0, t0);
        check("ldh_data", last_mem_data, 32'h000080FF);
        check("ldh_latency", 32'(last_mem_cyc - t0), 32'd4);

        do_req(1'b1, 1'b0, 32'h100, 2'b00, 32'h0, t0);
        check("ldb_latency", 32'(last_mem_cyc - t0), 32'd3);

        do_req(1'b1, 1'b0, 32'hFFFFFFFE, 2'b11, 32'h0, t0);
        for (int k = 0; k < 4; k++)
            check("wrap_addr", a_log.exists(t0 + 1 + k) ? a_log[t0 + 1 + k] : 32'hDEAD_0000, wrap_exp[k]);
        check("wrap_data", last_mem_data, 32'h44332211);

        do_req(1'b1, 1'b1, 32'h40, 2'b10, 32'hDEADBEEF, t0);
        check("stw_latency", 32'(last_mem_cyc - t0), 32'd5);
        do_req(1'b1, 1'b0, 32'h40, 2'b10, 32'h0, t0);
        check("ldw_back", last_mem_data, 32'hDEADBEEF);
        do_req(1'b1, 1'b1, 32'h41, 2'b01, 32'h00001234, t0);
        do_req(1'b1, 1'b0, 32'h42, 2'b00, 32'h0, t0);
        check("ldb_zext", last_mem_data, 32'h00000012);
        do_req(1'b0, 1'b0, 32'h40, 2'b00, 32'h0, t0);
        check("fetch_mixed", last_if_data, 32'hDE1234EF);

        contend(32'h100, 32'h20, 2'b00);
`ifndef MEM_CTRL_RR_ARB_EN
        check("contend_if_gap", 32'(last_if_cyc - last_mem_cyc), 32'd7);
`endif
        contend(32'h40, 32'h100, 2'b01);
        wait_cyc(cyc + 2);

        // Word store aborted by reset during its second write cycle
        @(posedge clk);
        #1;
        t0 = cyc;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h50; mem_len = 2'b10; mem_wdata = 32'hCAFEF00D;
        exp_a[t0 + 1] = 32'h50; exp_wr[t0 + 1] = 1'b1; exp_dout[t0 + 1] = 8'h0D; exp_busy[t0 + 1] = 1'b1;
        exp_a[t0 + 2] = 32'h51; exp_wr[t0 + 2] = 1'b1; exp_dout[t0 + 2] = 8'hF0; exp_busy[t0 + 2] = 1'b1;
        last_mem_cyc = -1;
        wait_cyc(t0 + 2);
        rst = 1'b0;
        wait_cyc(t0 + 3);
        rst = 1'b1;
        mem_req = 1'b0;
        m_last_mem = 1'b0;
        @(negedge clk);
        check("abort_dout", {24'b0, ram_dout}, 32'h0);
        wait_cyc(t0 + 8);
        check("abort_no_done", 32'(last_mem_cyc), 32'hFFFFFFFF);
        check("abort_b0", {24'b0, env_mem.exists(32'h50) ? env_mem[32'h50] : 8'h00}, 32'h0D);
        check("abort_b1", {24'b0, env_mem.exists(32'h51) ? env_mem[32'h51] : 8'h00}, 32'hF0);
        check("abort_b2", {24'b0, env_mem.exists(32'h52) ? env_mem[32'h52] : 8'h00}, 32'h00);
        ref_mem[32'h50] = 8'h0D;
        ref_mem[32'h51] = 8'hF0;

        do_req(1'b1, 1'b0, 32'h50, 2'b10, 32'h0, t0);
        check("post_abort_ld", last_mem_data, 32'h0000F00D);
        wait_cyc(cyc + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
